// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle shared between the arbitrating master and the slave side.
interface apb_master_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter in front of a single APB master port. One transfer is in
// flight at a time: IDLE (grant) -> SETUP -> ACCESS (wait states / timeout).
module apb_master_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESET_N,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   apb_master_arbiter_if.master             apb
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         ptr_q;      // last winner; also the owner of the in-flight transfer
   logic [PW-1:0]         cand, gnt_idx;
   logic                  gnt_any;
   logic [NUM_REQ-1:0]    gnt;
   logic                  hs;
   logic                  to_hit;
   logic [CW-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  psel_q, penable_q, pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;

   assign apb.PADDR   = paddr_q;
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PWDATA  = pwdata_q;

   // First valid requester scanning upward from the one after the last winner
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   assign gnt       = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
   // Gated by reset so every output reads 0 while PRESET_N is low
   assign req_ready = (state_q == IDLE && PRESET_N) ? gnt : '0;
   assign hs        = |(req_valid & req_ready);
   // cnt_q counts earlier low-PREADY edges, so this edge is the TIMEOUT-th one
   assign to_hit    = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge PCLK or negedge PRESET_N) begin
      if (!PRESET_N) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (apb.PREADY || to_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered APB drive, RR pointer, wait counter and response outputs
   always_ff @(posedge PCLK or negedge PRESET_N) begin
      if (!PRESET_N) begin
         ptr_q     <= PW'(NUM_REQ - 1);
         cnt_q     <= '0;
         paddr_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state_q)
            IDLE: if (hs) begin
               paddr_q   <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               pwdata_q  <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
               pwrite_q  <= req_write[gnt_idx];
               ptr_q     <= gnt_idx;
               psel_q    <= 1'b1;
               penable_q <= 1'b0;
            end
            SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  rsp_valid <= NUM_REQ'(1) << ptr_q;
                  rsp_rdata <= pwrite_q ? '0 : apb.PRDATA;
                  rsp_err   <= 1'b0;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (to_hit) begin
                     rsp_valid <= NUM_REQ'(1) << ptr_q;
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b1;
                     psel_q    <= 1'b0;
                     penable_q <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
